// File: rtl/bp_me_mem_requester_pkg.sv
// bp_me_mem_requester_pkg: BedRock mem header types, requester FSM states and store-data replication helper.
package bp_me_mem_requester_pkg;

   localparam int paddr_width_gp  = 40;
   localparam int did_width_gp    = 4;
   localparam int lce_id_width_gp = 4;
   localparam int dword_width_gp  = 64;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3
   } bp_bedrock_mem_type_e;

   typedef struct packed {
      logic [2:0]                 state;
      logic [2:0]                 way_id;
      logic [lce_id_width_gp-1:0] lce_id;
      logic [did_width_gp-1:0]    did;
      logic                       speculative;
   } bp_bedrock_mem_payload_s;

   typedef struct packed {
      bp_bedrock_mem_payload_s    payload;
      logic [2:0]                 size;
      logic [paddr_width_gp-1:0]  addr;
      logic [3:0]                 subop;
      bp_bedrock_mem_type_e       msg_type;
   } bp_bedrock_mem_header_s;

   localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

   typedef enum logic [1:0] {e_ready, e_send, e_wait, e_reply} bp_me_requester_state_e;

   // Copies the low 2^size bytes across the whole dword, as responders expect for narrow stores
   function automatic logic [dword_width_gp-1:0] replicate_dword(input logic [dword_width_gp-1:0] data,
                                                                 input logic [1:0] size);
      return (size == 2'd0) ? {8{data[7:0]}}
           : (size == 2'd1) ? {4{data[15:0]}}
           : (size == 2'd2) ? {2{data[31:0]}}
           : data;
   endfunction

endpackage

// File: rtl/bp_me_mem_requester.sv
// bp_me_mem_requester: single-outstanding uncached BedRock mem command initiator.
// Define BP_ME_REQUESTER_TIMEOUT_EN to bound the response wait by timeout_cycles_p.
module bp_me_mem_requester
   import bp_me_mem_requester_pkg::*;
#(
   parameter int timeout_cycles_p = 1024
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [did_width_gp-1:0]        did_i,
   input  logic [lce_id_width_gp-1:0]     lce_id_i,
   input  logic                           req_v_i,
   output logic                           req_ready_and_o,
   input  logic                           req_we_i,
   input  logic [paddr_width_gp-1:0]      req_addr_i,
   input  logic [1:0]                     req_size_i,
   input  logic [dword_width_gp-1:0]      req_data_i,
   output logic [mem_header_width_gp-1:0] mem_cmd_header_o,
   output logic [dword_width_gp-1:0]      mem_cmd_critical_o,
   output logic                           mem_cmd_header_v_o,
   input  logic                           mem_cmd_header_ready_and_i,
   input  logic [mem_header_width_gp-1:0] mem_resp_header_i,
   input  logic [dword_width_gp-1:0]      mem_resp_critical_i,
   input  logic                           mem_resp_header_v_i,
   output logic                           mem_resp_header_ready_and_o,
   output logic                           resp_v_o,
   output logic [dword_width_gp-1:0]      resp_data_o,
   output logic                           resp_err_o,
   input  logic                           resp_yumi_i
);

   bp_me_requester_state_e state_r, state_n;
   bp_bedrock_mem_header_s cmd_header_r, req_header, resp_header;
   logic [dword_width_gp-1:0] critical_r, resp_data_r;
   logic resp_err_r, cmd_hs, resp_hs, timeout, mismatch, unused_resp;

   assign resp_header                 = mem_resp_header_i;
   assign req_ready_and_o             = (state_r == e_ready);
   assign mem_cmd_header_v_o          = (state_r == e_send);
   assign mem_resp_header_ready_and_o = (state_r == e_wait);
   assign resp_v_o                    = (state_r == e_reply);
   assign mem_cmd_header_o            = cmd_header_r;
   assign mem_cmd_critical_o          = critical_r;
   assign resp_data_o                 = resp_data_r;
   assign resp_err_o                  = resp_err_r;
   assign cmd_hs                      = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
   assign resp_hs                     = mem_resp_header_ready_and_o & mem_resp_header_v_i;
   assign mismatch = (resp_header.msg_type != cmd_header_r.msg_type)
                   | (resp_header.addr != cmd_header_r.addr)
                   | (resp_header.size != cmd_header_r.size);
   assign unused_resp = ^{resp_header.payload, resp_header.subop};

`ifdef BP_ME_REQUESTER_TIMEOUT_EN
   localparam int cnt_width_lp = $clog2(timeout_cycles_p + 1);
   logic [cnt_width_lp-1:0] cnt_r;

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i)              cnt_r <= '0;
      else if (cmd_hs)             cnt_r <= '0;
      else if (state_r == e_wait)  cnt_r <= cnt_r + cnt_width_lp'(1);

   // Fires as the counter steps to timeout_cycles_p; a same-cycle response takes priority
   assign timeout = (state_r == e_wait) & ~mem_resp_header_v_i
                  & (cnt_r == cnt_width_lp'(timeout_cycles_p - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      req_header                = '0;
      req_header.msg_type       = req_we_i ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
      req_header.addr           = req_addr_i;
      req_header.size           = {1'b0, req_size_i};
      req_header.payload.did    = did_i;
      req_header.payload.lce_id = lce_id_i;
   end

   always_comb begin
      state_n = (state_r == e_ready && req_v_i)              ? e_send
              : (state_r == e_send  && cmd_hs)               ? e_wait
              : (state_r == e_wait  && (resp_hs || timeout)) ? e_reply
              : (state_r == e_reply && resp_yumi_i)          ? e_ready
              : state_r;
   end

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) state_r <= e_ready;
      else            state_r <= state_n;

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         cmd_header_r <= '0;
         critical_r   <= '0;
         resp_data_r  <= '0;
         resp_err_r   <= 1'b0;
      end else begin
         if (req_v_i && req_ready_and_o) begin
            cmd_header_r <= req_header;
            critical_r   <= req_we_i ? replicate_dword(req_data_i, req_size_i) : '0;
         end
         if (resp_hs || timeout) begin
            resp_data_r <= resp_hs ? mem_resp_critical_i : '0;
            resp_err_r  <= resp_hs ? mismatch : 1'b1;
         end
      end

endmodule

// File: tb/tb_bp_me_mem_requester.sv
// tb_bp_me_mem_requester: directed self-checking bench for bp_me_mem_requester.
// Timeout scenario runs only when BP_ME_REQUESTER_TIMEOUT_EN is defined.
module tb_bp_me_mem_requester;
   import bp_me_mem_requester_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                           reset_n;
   logic [did_width_gp-1:0]        did;
   logic [lce_id_width_gp-1:0]     lce_id;
   logic                           req_v, req_ready, req_we;
   logic [paddr_width_gp-1:0]      req_addr;
   logic [1:0]                     req_size;
   logic [dword_width_gp-1:0]      req_data;
   logic [mem_header_width_gp-1:0] cmd_header;
   logic [dword_width_gp-1:0]      cmd_critical;
   logic                           cmd_v, cmd_ready;
   logic [mem_header_width_gp-1:0] rsp_header;
   logic [dword_width_gp-1:0]      rsp_critical;
   logic                           rsp_v, rsp_ready;
   logic                           resp_v;
   logic [dword_width_gp-1:0]      resp_data;
   logic                           resp_err, resp_yumi;

   int checks = 0;
   int errors = 0;

   bp_me_mem_requester #(.timeout_cycles_p(8)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .did_i(did), .lce_id_i(lce_id),
      .req_v_i(req_v), .req_ready_and_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_size_i(req_size), .req_data_i(req_data),
      .mem_cmd_header_o(cmd_header), .mem_cmd_critical_o(cmd_critical),
      .mem_cmd_header_v_o(cmd_v), .mem_cmd_header_ready_and_i(cmd_ready),
      .mem_resp_header_i(rsp_header), .mem_resp_critical_i(rsp_critical),
      .mem_resp_header_v_i(rsp_v), .mem_resp_header_ready_and_o(rsp_ready),
      .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_err_o(resp_err),
      .resp_yumi_i(resp_yumi)
   );

   function automatic bp_bedrock_mem_header_s mk_hdr(input logic we, input logic [paddr_width_gp-1:0] addr,
                                                     input logic [1:0] size);
      bp_bedrock_mem_header_s h;
      h                = '0;
      h.msg_type       = we ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
      h.addr           = addr;
      h.size           = {1'b0, size};
      h.payload.did    = 4'h5;
      h.payload.lce_id = 4'h3;
      return h;
   endfunction

   // Inputs change and outputs are sampled only at negedges
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic we, input logic [paddr_width_gp-1:0] addr, input logic [1:0] size,
                        input logic [dword_width_gp-1:0] data);
      req_v = 1'b1; req_we = we; req_addr = addr; req_size = size; req_data = data;
      tick();
      req_v = 1'b0;
   endtask

   task automatic handshake_cmd();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
   endtask

   task automatic respond(input bp_bedrock_mem_header_s h, input logic [dword_width_gp-1:0] data);
      rsp_header = h; rsp_critical = data; rsp_v = 1'b1;
      tick();
      rsp_v = 1'b0;
   endtask

   task automatic consume();
      resp_yumi = 1'b1;
      tick();
      resp_yumi = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; did = 4'h5; lce_id = 4'h3;
      req_v = 0; req_we = 0; req_addr = '0; req_size = 0; req_data = '0;
      cmd_ready = 0; rsp_header = '0; rsp_critical = '0; rsp_v = 0; resp_yumi = 0;
      @(negedge clk); @(negedge clk);
      checks++; if (cmd_v !== 1'b0) begin errors++; $display("FAIL reset_cmd_v: got %b want 0", cmd_v); end
      checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready: got %b want 0", rsp_ready); end
      checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL reset_resp_v: got %b want 0", resp_v); end
      checks++; if (cmd_header !== '0) begin errors++; $display("FAIL reset_header: got %h want 0", cmd_header); end
      checks++; if (cmd_critical !== '0) begin errors++; $display("FAIL reset_critical: got %h want 0", cmd_critical); end
      checks++; if (resp_data !== '0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got data %h err %b want 0 0", resp_data, resp_err); end
      reset_n = 1'b1;
      tick();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_read_loopback();
      bp_bedrock_mem_header_s h = mk_hdr(1'b0, 40'h80_0000_0010, 2'd3);
      req_v = 1'b1; req_we = 1'b0; req_addr = 40'h80_0000_0010; req_size = 2'd3; req_data = 64'hdead_beef_dead_beef;
      #1;
      checks++; if (cmd_v !== 1'b0) begin errors++; $display("FAIL rd_cmd_v_comb: got %b want 0", cmd_v); end
      @(negedge clk);
      tick();
      req_v = 1'b0;
      checks++; if (cmd_v !== 1'b1) begin errors++; $display("FAIL rd_cmd_v: got %b want 1", cmd_v); end
      checks++; if (cmd_header !== h) begin errors++; $display("FAIL rd_header: got %h want %h", cmd_header, h); end
      checks++; if (cmd_critical !== '0) begin errors++; $display("FAIL rd_critical: got %h want 0", cmd_critical); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rd_req_ready: got %b want 0", req_ready); end
      handshake_cmd();
      checks++; if (cmd_v !== 1'b0 || rsp_ready !== 1'b1) begin errors++; $display("FAIL rd_wait: got cmd_v %b rsp_ready %b want 0 1", cmd_v, rsp_ready); end
      respond(h, 64'h0);
      checks++; if (resp_v !== 1'b1 || rsp_ready !== 1'b0) begin errors++; $display("FAIL rd_reply: got resp_v %b rsp_ready %b want 1 0", resp_v, rsp_ready); end
      checks++; if (resp_data !== 64'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL rd_resp: got data %h err %b want 0 0", resp_data, resp_err); end
      consume();
      checks++; if (resp_v !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rd_done: got resp_v %b req_ready %b want 0 1", resp_v, req_ready); end
   endtask

   task automatic test_write_replication();
      logic [1:0]                size_v[3] = '{2'd0, 2'd1, 2'd2};
      logic [dword_width_gp-1:0] data_v[3] = '{64'h1122_3344_5566_77a5, 64'h1122_3344_5566_beef, 64'h0011_2233_89ab_cdef};
      logic [dword_width_gp-1:0] exp_v[3]  = '{64'ha5a5_a5a5_a5a5_a5a5, 64'hbeef_beef_beef_beef, 64'h89ab_cdef_89ab_cdef};
      for (int i = 0; i < 3; i++) begin
         bp_bedrock_mem_header_s h = mk_hdr(1'b1, 40'h80_0000_0100, size_v[i]);
         issue(1'b1, 40'h80_0000_0100, size_v[i], data_v[i]);
         checks++; if (cmd_critical !== exp_v[i]) begin errors++; $display("FAIL wr_critical[%0d]: got %h want %h", i, cmd_critical, exp_v[i]); end
         checks++; if (cmd_header !== h) begin errors++; $display("FAIL wr_header[%0d]: got %h want %h", i, cmd_header, h); end
         handshake_cmd();
         respond(h, 64'h0);
         checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL wr_err[%0d]: got %b want 0", i, resp_err); end
         consume();
      end
   endtask

   task automatic test_backpressure();
      bp_bedrock_mem_header_s h = mk_hdr(1'b1, 40'h80_0000_0040, 2'd3);
      issue(1'b1, 40'h80_0000_0040, 2'd3, 64'h0123_4567_89ab_cdef);
      req_v = 1'b1; req_we = 1'b0; req_addr = 40'h80_0000_0099; req_data = '0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (cmd_v !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_valid[%0d]: got cmd_v %b req_ready %b want 1 0", i, cmd_v, req_ready); end
         checks++; if (cmd_header !== h) begin errors++; $display("FAIL bp_header[%0d]: got %h want %h", i, cmd_header, h); end
         checks++; if (cmd_critical !== 64'h0123_4567_89ab_cdef) begin errors++; $display("FAIL bp_critical[%0d]: got %h want 0123456789abcdef", i, cmd_critical); end
         tick();
      end
      handshake_cmd();
      req_v = 1'b0;
      checks++; if (cmd_v !== 1'b0 || rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_single: got cmd_v %b rsp_ready %b want 0 1", cmd_v, rsp_ready); end
      respond(h, 64'h0);
      consume();
   endtask

   task automatic test_mismatch();
      bp_bedrock_mem_header_s h = mk_hdr(1'b0, 40'h80_0000_0010, 2'd3);
      bp_bedrock_mem_header_s bad = h;
      bad.addr = 40'h80_0000_0018;
      issue(1'b0, 40'h80_0000_0010, 2'd3, '0);
      rsp_header = bad; rsp_critical = 64'hffff_0000_ffff_0000; rsp_v = 1'b1;
      checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL mm_early_ready: got %b want 0", rsp_ready); end
      handshake_cmd();
      respond(bad, 64'h0123_4567_89ab_cdef);
      checks++; if (resp_v !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL mm_err: got resp_v %b err %b want 1 1", resp_v, resp_err); end
      checks++; if (resp_data !== 64'h0123_4567_89ab_cdef) begin errors++; $display("FAIL mm_data: got %h want 0123456789abcdef", resp_data); end
      consume();
   endtask

   task automatic test_client_stall();
      bp_bedrock_mem_header_s h = mk_hdr(1'b0, 40'h80_0000_0008, 2'd2);
      issue(1'b0, 40'h80_0000_0008, 2'd2, '0);
      handshake_cmd();
      respond(h, 64'h0000_0000_cafe_f00d);
      req_v = 1'b1; req_we = 1'b0; req_addr = 40'h80_0000_0020; req_size = 2'd3;
      for (int i = 0; i < 10; i++) begin
         checks++; if (resp_v !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL stall[%0d]: got resp_v %b req_ready %b want 1 0", i, resp_v, req_ready); end
         checks++; if (resp_data !== 64'h0000_0000_cafe_f00d) begin errors++; $display("FAIL stall_data[%0d]: got %h want cafef00d", i, resp_data); end
         tick();
      end
      resp_yumi = 1'b1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_yumi_cycle: got req_ready %b want 0", req_ready); end
      tick();
      resp_yumi = 1'b0;
      checks++; if (req_ready !== 1'b1 || resp_v !== 1'b0 || cmd_v !== 1'b0) begin errors++; $display("FAIL stall_after: got req_ready %b resp_v %b cmd_v %b want 1 0 0", req_ready, resp_v, cmd_v); end
      tick();
      req_v = 1'b0;
      checks++; if (cmd_v !== 1'b1 || cmd_header !== mk_hdr(1'b0, 40'h80_0000_0020, 2'd3)) begin errors++; $display("FAIL stall_next: got cmd_v %b header %h", cmd_v, cmd_header); end
      handshake_cmd();
      respond(mk_hdr(1'b0, 40'h80_0000_0020, 2'd3), 64'h0);
      consume();
   endtask

   task automatic test_async_reset();
      issue(1'b1, 40'h80_0000_0030, 2'd3, 64'h5555_aaaa_5555_aaaa);
      handshake_cmd();
      checks++; if (rsp_ready !== 1'b1) begin errors++; $display("FAIL ar_wait: got rsp_ready %b want 1", rsp_ready); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (cmd_v !== 1'b0 || rsp_ready !== 1'b0 || resp_v !== 1'b0) begin errors++; $display("FAIL ar_valids: got cmd_v %b rsp_ready %b resp_v %b want 0 0 0", cmd_v, rsp_ready, resp_v); end
      checks++; if (cmd_header !== '0 || cmd_critical !== '0) begin errors++; $display("FAIL ar_regs: got header %h critical %h want 0 0", cmd_header, cmd_critical); end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      checks++; if (req_ready !== 1'b1 || resp_v !== 1'b0) begin errors++; $display("FAIL ar_release: got req_ready %b resp_v %b want 1 0", req_ready, resp_v); end
   endtask

`ifdef BP_ME_REQUESTER_TIMEOUT_EN
   task automatic test_timeout();
      issue(1'b0, 40'h80_0000_0050, 2'd3, '0);
      handshake_cmd();
      for (int i = 0; i < 8; i++) begin
         checks++; if (resp_v !== 1'b0 || rsp_ready !== 1'b1) begin errors++; $display("FAIL to_wait[%0d]: got resp_v %b rsp_ready %b want 0 1", i, resp_v, rsp_ready); end
         tick();
      end
      checks++; if (resp_v !== 1'b1 || resp_err !== 1'b1 || resp_data !== '0) begin errors++; $display("FAIL to_reply: got resp_v %b err %b data %h want 1 1 0", resp_v, resp_err, resp_data); end
      consume();
   endtask
`endif

   initial begin
      test_reset();
      test_read_loopback();
      test_write_replication();
      test_backpressure();
      test_mismatch();
      test_client_stall();
`ifdef BP_ME_REQUESTER_TIMEOUT_EN
      test_timeout();
`endif
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
